// File: rtl/ldm_stm_seq_if.sv
// ---------------------------------------------------------------------------
// ldm_stm_seq_if
// Bundles the decoded LDM/STM instruction, the register-file ports, the
// memory handshake and the PC-load/stall/done status of the block-transfer
// sequencer.
//   master : the sequencer (drives rf_*, mem_*, pc_*, busy, done)
//   slave  : decoder / register file / memory side (drives start, bits, data)
// ---------------------------------------------------------------------------
interface ldm_stm_seq_if #(
  parameter int unsigned AW = 32
);
  // decoded instruction
  logic          start;
  logic          l_bit;
  logic          p_bit;
  logic          u_bit;
  logic          w_bit;
  logic [3:0]    rn;
  logic [AW-1:0] base;
  logic [15:0]   reglist;
  // register file
  logic [AW-1:0] rf_rd2;
  logic [3:0]    rf_a2;
  logic [3:0]    rf_a3;
  logic [AW-1:0] rf_wd3;
  logic          rf_we3;
  // memory
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [AW-1:0] mem_wdata;
  logic          mem_ready;
  logic [AW-1:0] mem_rdata;
  // status
  logic          pc_load;
  logic [AW-1:0] pc_value;
  logic          busy;
  logic          done;

  modport master (
    input  start, l_bit, p_bit, u_bit, w_bit, rn, base, reglist,
    input  rf_rd2, mem_ready, mem_rdata,
    output rf_a2, rf_a3, rf_wd3, rf_we3,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output pc_load, pc_value, busy, done
  );

  modport slave (
    output start, l_bit, p_bit, u_bit, w_bit, rn, base, reglist,
    output rf_rd2, mem_ready, mem_rdata,
    input  rf_a2, rf_a3, rf_wd3, rf_we3,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  pc_load, pc_value, busy, done
  );
endinterface

// File: rtl/ldm_stm_seq.sv
// ---------------------------------------------------------------------------
// ldm_stm_seq
// Multi-cycle sequencer for ARM LDM/STM block transfers. Walks the register
// list lowest index first, one word per accepted memory handshake, then does
// the optional base writeback and pulses done. busy stalls the datapath.
//
// Ports:
//   clk    : clock, all state changes on the rising edge
//   reset  : synchronous, active-high
//   bus    : ldm_stm_seq_if.master (instruction in, register file A2/A3/WD3/
//            WE3 and RD2, memory req/we/addr/wdata/ready/rdata, pc_load,
//            pc_value, busy, done)
//
// Optional feature macro: LDM_STM_PC_LOAD_EN
//   defined   : LDM of R15 performs the access and reports it via pc_load
//   undefined : R15 is dropped from LDM lists, pc_load/pc_value tied to 0
// ---------------------------------------------------------------------------
module ldm_stm_seq #(
  parameter int unsigned AW = 32
) (
  input  logic         clk,
  input  logic         reset,
  ldm_stm_seq_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_WB   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        r_state;
  logic [15:0]   r_list;     // registers still to transfer
  logic          r_l;        // 1 = load
  logic          r_wb_en;    // writeback pending at end of list
  logic [3:0]    r_rn;
  logic [AW-1:0] r_addr;     // address of the current word
  logic [AW-1:0] r_wb_val;   // final base value, computed at start

  logic [15:0]   w_list_eff;
  logic [4:0]    w_n;
  logic [AW-1:0] w_span;
  logic [AW-1:0] w_start_addr;
  logic [AW-1:0] w_wb_val;
  logic          w_wb_en;
  logic [3:0]    w_idx;
  logic [15:0]   w_list_next;
  logic          w_xfer;
  logic          w_hs;
  logic          w_ld_hs;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
    return c;
  endfunction

  // Register list as it will be walked; R15 only survives for LDM when the
  // PC-load path exists.
  always_comb begin
`ifdef LDM_STM_PC_LOAD_EN
    w_list_eff = bus.reglist;
`else
    w_list_eff = bus.l_bit ? {1'b0, bus.reglist[14:0]} : bus.reglist;
`endif
  end

  // Start address and writeback value; every mode walks addresses upward.
  always_comb begin
    w_n    = popcount16(w_list_eff);
    w_span = AW'(w_n) << 2;
    unique case ({bus.p_bit, bus.u_bit})
      2'b01:   w_start_addr = bus.base;                      // IA
      2'b11:   w_start_addr = bus.base + AW'(4);             // IB
      2'b00:   w_start_addr = bus.base - w_span + AW'(4);    // DA
      default: w_start_addr = bus.base - w_span;             // DB
    endcase
    w_wb_val = bus.u_bit ? (bus.base + w_span) : (bus.base - w_span);
    // Loaded base wins over writeback; R15 is never written via A3.
    w_wb_en  = bus.w_bit & ~(bus.l_bit & bus.reglist[bus.rn]) & (bus.rn != 4'd15);
  end

  // Lowest set index of the remaining list.
  always_comb begin
    w_idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (r_list[i]) w_idx = 4'(i);
    end
  end

  assign w_list_next = r_list & (r_list - 16'd1);
  assign w_xfer      = (r_state == S_XFER) & ~reset;
  assign w_hs        = w_xfer & bus.mem_ready;
  assign w_ld_hs     = w_hs & r_l;

  // Sequencer state and latched transfer context.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_list   <= '0;
      r_l      <= 1'b0;
      r_wb_en  <= 1'b0;
      r_rn     <= '0;
      r_addr   <= '0;
      r_wb_val <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_list   <= w_list_eff;
            r_l      <= bus.l_bit;
            r_wb_en  <= w_wb_en;
            r_rn     <= bus.rn;
            r_addr   <= w_start_addr;
            r_wb_val <= w_wb_val;
            r_state  <= (w_n == 5'd0) ? S_DONE : S_XFER;
          end
        end
        S_XFER: begin
          if (w_hs) begin
            r_list <= w_list_next;
            r_addr <= r_addr + AW'(4);
            if (w_list_next == 16'd0) r_state <= r_wb_en ? S_WB : S_DONE;
          end
        end
        S_WB:    r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory side: address/index held by registers until the handshake.
  assign bus.mem_req   = w_xfer;
  assign bus.mem_we    = w_xfer & ~r_l;
  assign bus.mem_addr  = {r_addr[AW-1:2], 2'b00};
  assign bus.mem_wdata = bus.rf_rd2;
  assign bus.rf_a2     = w_idx;

  // Register-file write port: loaded word in the handshake cycle, or base
  // writeback in the WB cycle.
  assign bus.rf_we3 = (w_ld_hs & (w_idx != 4'd15)) | ((r_state == S_WB) & ~reset);
  assign bus.rf_a3  = (r_state == S_WB) ? r_rn : w_idx;
  assign bus.rf_wd3 = (r_state == S_WB) ? r_wb_val : bus.mem_rdata;

`ifdef LDM_STM_PC_LOAD_EN
  assign bus.pc_load  = w_ld_hs & (w_idx == 4'd15);
  assign bus.pc_value = {bus.mem_rdata[AW-1:2], 2'b00};
`else
  assign bus.pc_load  = 1'b0;
  assign bus.pc_value = '0;
`endif

  assign bus.busy = ~reset & (bus.start | (r_state != S_IDLE));
  assign bus.done = ~reset & (r_state == S_DONE);

endmodule

// File: tb/tb_ldm_stm_seq.sv
module tb_ldm_stm_seq;
  localparam int unsigned AW = 32;
`ifdef LDM_STM_PC_LOAD_EN
  localparam bit PCEN = 1'b1;
`else
  localparam bit PCEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ldm_stm_seq_if #(.AW(AW)) bus ();
  ldm_stm_seq #(.AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic l, p, u, w;
    logic [3:0]  rn;
    logic [31:0] base;
    logic [15:0] reglist;
  } txn_t;

  typedef struct {
    txn_t        t;
    int          exp_n;
    logic [31:0] exp_first;
    bit          exp_wb;
    logic [31:0] exp_wbval;
    int          exp_done;
  } vec_t;

  // Bench-side register file and memory data source
  logic [31:0] regs [16];
  logic [31:0] salt;
  bit          ovr_en;
  logic [31:0] ovr_val;
  assign bus.rf_rd2 = regs[bus.rf_a2];

  int n_chk = 0;
  int n_fail = 0;

  // Observations of one transaction
  logic [31:0] obs_addr[$];
  logic        obs_we[$];
  logic [3:0]  obs_idx[$];
  logic [31:0] obs_wdata[$];
  int          obs_hs_cyc[$];
  logic [3:0]  wr_a3[$];
  logic [31:0] wr_d[$];
  logic [31:0] pcv[$];
  int          done_cyc[$];
  int          wb_cyc;
  bit          wb_seen;
  logic [31:0] wb_val;
  int          busy_bad;
  int          a3_15;

  function automatic logic [31:0] rdfn(input logic [31:0] a);
    if (ovr_en) return ovr_val;
    return {a[15:0], a[31:16]} ^ salt;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    bus.start = 1'b0; bus.l_bit = 1'b0; bus.p_bit = 1'b0; bus.u_bit = 1'b0;
    bus.w_bit = 1'b0; bus.rn = '0; bus.base = '0; bus.reglist = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
  endtask

  task automatic drive_txn(input txn_t t);
    bus.l_bit = t.l; bus.p_bit = t.p; bus.u_bit = t.u; bus.w_bit = t.w;
    bus.rn = t.rn; bus.base = t.base; bus.reglist = t.reglist;
  endtask

  task automatic sample(input int c);
    if (done_cyc.size() == 0 && bus.busy !== 1'b1) busy_bad++;
    if (bus.mem_req && bus.mem_ready) begin
      obs_addr.push_back(bus.mem_addr);
      obs_we.push_back(bus.mem_we);
      obs_idx.push_back(bus.rf_a2);
      obs_wdata.push_back(bus.mem_wdata);
      obs_hs_cyc.push_back(c);
    end
    if (bus.rf_we3) begin
      wr_a3.push_back(bus.rf_a3);
      wr_d.push_back(bus.rf_wd3);
      if (bus.rf_a3 == 4'd15) a3_15++;
      if (!bus.mem_req) begin
        wb_seen = 1'b1; wb_val = bus.rf_wd3; wb_cyc = c;
      end
      regs[bus.rf_a3] = bus.rf_wd3;
    end
    if (bus.pc_load) pcv.push_back(bus.pc_value);
    if (bus.done) done_cyc.push_back(c);
  endtask

  // Start one transfer (start cycle = 0) and follow it to done.
  task automatic run_txn(input txn_t t, input int ready_pct);
    obs_addr.delete(); obs_we.delete(); obs_idx.delete(); obs_wdata.delete();
    obs_hs_cyc.delete(); wr_a3.delete(); wr_d.delete(); pcv.delete(); done_cyc.delete();
    wb_seen = 1'b0; wb_val = '0; wb_cyc = -1; busy_bad = 0; a3_15 = 0;
    @(posedge clk); #1;
    drive_txn(t);
    bus.start = 1'b1;
    bus.mem_ready = ($urandom_range(99) < ready_pct);
    bus.mem_rdata = rdfn(bus.mem_addr);
    @(negedge clk); sample(0);
    for (int c = 1; c <= 200 && done_cyc.size() == 0; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.mem_ready = ($urandom_range(99) < ready_pct);
      bus.mem_rdata = rdfn(bus.mem_addr);
      @(negedge clk); sample(c);
    end
    chk("done_seen", 32'(done_cyc.size()), 32'd1);
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("busy_after_done", 32'(bus.busy), 32'd0);
  endtask

  // Reference: list walked in ascending register order over a contiguous
  // ascending block of words; loads land in registers, R15 goes to the PC.
  task automatic check_model(input txn_t t, input logic [31:0] r0 [16]);
    int idxq[$];
    logic [3:0]  ea[$];
    logic [31:0] ed[$];
    logic [31:0] ep[$];
    logic [31:0] span, lo, a;
    bit wb;
    int n, last_hs, exp_done;
    for (int i = 0; i < 16; i++)
      if (t.reglist[i] && !(i == 15 && t.l && !PCEN)) idxq.push_back(i);
    n = idxq.size();
    span = 32'(4 * n);
    lo = t.u ? t.base + (t.p ? 32'd4 : 32'd0) : t.base - span + (t.p ? 32'd0 : 32'd4);
    chk("hs_count", 32'(obs_addr.size()), 32'(n));
    for (int k = 0; k < n && k < obs_addr.size(); k++) begin
      a = lo + 32'(4 * k);
      chk("hs_addr", obs_addr[k], a);
      chk("hs_we", 32'(obs_we[k]), 32'(!t.l));
      chk("hs_idx", 32'(obs_idx[k]), 32'(idxq[k]));
      if (!t.l) chk("st_data", obs_wdata[k], r0[idxq[k]]);
      else if (idxq[k] == 15) ep.push_back(rdfn(a) & ~32'd3);
      else begin ea.push_back(4'(idxq[k])); ed.push_back(rdfn(a)); end
    end
    wb = t.w && n > 0 && !(t.l && t.reglist[t.rn]) && t.rn != 4'd15;
    if (wb) begin
      ea.push_back(t.rn);
      ed.push_back(t.u ? t.base + span : t.base - span);
    end
    chk("wr_count", 32'(wr_a3.size()), 32'(ea.size()));
    for (int k = 0; k < ea.size() && k < wr_a3.size(); k++) begin
      chk("wr_a3", 32'(wr_a3[k]), 32'(ea[k]));
      chk("wr_wd3", wr_d[k], ed[k]);
    end
    chk("pc_count", 32'(pcv.size()), 32'(ep.size()));
    for (int k = 0; k < ep.size() && k < pcv.size(); k++) chk("pc_value", pcv[k], ep[k]);
    last_hs  = (obs_hs_cyc.size() > 0) ? obs_hs_cyc[$] : 0;
    exp_done = (n == 0) ? 1 : last_hs + 1 + int'(wb);
    if (done_cyc.size() > 0) chk("done_cycle", 32'(done_cyc[0]), 32'(exp_done));
    if (wb) chk("wb_cycle", 32'(wb_cyc), 32'(last_hs + 1));
    chk("busy_held", 32'(busy_bad), 32'd0);
    chk("a3_is_15", 32'(a3_15), 32'd0);
  endtask

  function automatic vec_t mkv(input logic l, p, u, w, input logic [3:0] rn,
                               input logic [31:0] base, input logic [15:0] rl,
                               input int n, input logic [31:0] first, input bit wb,
                               input logic [31:0] wbv, input int d);
    vec_t v;
    v.t.l = l; v.t.p = p; v.t.u = u; v.t.w = w; v.t.rn = rn;
    v.t.base = base; v.t.reglist = rl;
    v.exp_n = n; v.exp_first = first; v.exp_wb = wb; v.exp_wbval = wbv; v.exp_done = d;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    logic [31:0] r0 [16];
    txn_t t;

    // Directed vectors, memory always ready
    vecs[0] = mkv(1, 0, 1, 0, 4'd0,  32'h1000, 16'h000E, 3, 32'h1000, 0, 32'h0,    4);
    vecs[1] = mkv(0, 1, 0, 1, 4'd13, 32'h2000, 16'h4030, 3, 32'h1FF4, 1, 32'h1FF4, 5);
    vecs[2] = mkv(1, 0, 1, 1, 4'd2,  32'h3000, 16'h0006, 2, 32'h3000, 0, 32'h0,    3);
    vecs[3] = mkv(1, 0, 1, 1, 4'd1,  32'h0040, 16'h0000, 0, 32'h0,    0, 32'h0,    1);
    vecs[4] = mkv(0, 0, 1, 1, 4'd1,  32'h0100, 16'h0003, 2, 32'h0100, 1, 32'h0108, 4);
    vecs[5] = mkv(1, 0, 0, 1, 4'd3,  32'h4000, 16'h0101, 2, 32'h3FFC, 1, 32'h3FF8, 4);
    vecs[6] = mkv(0, 1, 1, 0, 4'd0,  32'h0010, 16'h8000, 1, 32'h0014, 0, 32'h0,    2);
`ifdef LDM_STM_PC_LOAD_EN
    vecs[7] = mkv(1, 0, 1, 0, 4'd0,  32'h0020, 16'h8000, 1, 32'h0020, 0, 32'h0,    2);
`else
    vecs[7] = mkv(1, 0, 1, 0, 4'd0,  32'h0020, 16'h8000, 0, 32'h0,    0, 32'h0,    1);
`endif
    vecs[8] = mkv(1, 1, 0, 1, 4'd4,  32'h1000, 16'h00F0, 4, 32'h0FF0, 0, 32'h0,    5);

    ovr_en = 1'b0; ovr_val = '0; salt = 32'h5A5A_1234;
    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    regs[15] = 32'h0000_8008;

    // Reset state
    reset = 1'b1;
    set_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_rf_we3",  32'(bus.rf_we3),  32'd0);
    chk("rst_pc_load", 32'(bus.pc_load), 32'd0);
    chk("rst_done",    32'(bus.done),    32'd0);
    chk("rst_busy",    32'(bus.busy),    32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int v = 0; v < 9; v++) begin
      regs[vecs[v].t.rn] = vecs[v].t.base;
      r0 = regs;
      salt = $urandom;
      run_txn(vecs[v].t, 100);
      chk("vec_n", 32'(obs_addr.size()), 32'(vecs[v].exp_n));
      if (vecs[v].exp_n > 0 && obs_addr.size() > 0) chk("vec_first", obs_addr[0], vecs[v].exp_first);
      chk("vec_wb", 32'(wb_seen), 32'(vecs[v].exp_wb));
      if (vecs[v].exp_wb) chk("vec_wbval", wb_val, vecs[v].exp_wbval);
      if (done_cyc.size() > 0) chk("vec_done", 32'(done_cyc[0]), 32'(vecs[v].exp_done));
      check_model(vecs[v].t, r0);
    end

    // LDM IB, single word, memory stalls three cycles
    @(posedge clk); #1;
    t = '{l:1, p:1, u:1, w:0, rn:4'd0, base:32'h0500, reglist:16'h0001};
    drive_txn(t); bus.start = 1'b1; bus.mem_ready = 1'b0;
    @(negedge clk); chk("stall_busy0", 32'(bus.busy), 32'd1);
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1; bus.start = 1'b0; bus.mem_ready = 1'b0;
      @(negedge clk);
      chk("stall_req",  32'(bus.mem_req), 32'd1);
      chk("stall_addr", bus.mem_addr, 32'h0504);
      chk("stall_we3",  32'(bus.rf_we3), 32'd0);
      chk("stall_busy", 32'(bus.busy), 32'd1);
    end
    @(posedge clk); #1; bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFE_0001;
    @(negedge clk);
    chk("stall_we3_rdy", 32'(bus.rf_we3), 32'd1);
    chk("stall_a3",      32'(bus.rf_a3), 32'd0);
    chk("stall_wd3",     bus.rf_wd3, 32'hCAFE_0001);
    @(posedge clk); #1; bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("stall_done", 32'(bus.done), 32'd1);
    chk("stall_req_end", 32'(bus.mem_req), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("stall_busy_end", 32'(bus.busy), 32'd0);

    // Empty list, then a second start while still busy is ignored
    @(posedge clk); #1;
    t = '{l:1, p:0, u:1, w:1, rn:4'd1, base:32'h0080, reglist:16'h0000};
    drive_txn(t); bus.start = 1'b1; bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("empty_busy", 32'(bus.busy), 32'd1);
    chk("empty_req",  32'(bus.mem_req), 32'd0);
    @(posedge clk); #1; bus.reglist = 16'h0001;
    @(negedge clk);
    chk("empty_done", 32'(bus.done), 32'd1);
    chk("empty_req2", 32'(bus.mem_req), 32'd0);
    chk("empty_we3",  32'(bus.rf_we3), 32'd0);
    @(posedge clk); #1; bus.start = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("ign_req",  32'(bus.mem_req), 32'd0);
      chk("ign_done", 32'(bus.done), 32'd0);
      chk("ign_busy", 32'(bus.busy), 32'd0);
      @(posedge clk); #1;
    end

    // Reset after the first of four words
    t = '{l:1, p:0, u:1, w:1, rn:4'd5, base:32'h0600, reglist:16'h000F};
    drive_txn(t); bus.start = 1'b1; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1111_0000;
    @(negedge clk);
    @(posedge clk); #1; bus.start = 1'b0;
    @(negedge clk);
    chk("rstx_req",  32'(bus.mem_req), 32'd1);
    chk("rstx_addr", bus.mem_addr, 32'h0600);
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    @(posedge clk); #1; reset = 1'b0;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      chk("rstx_req_off",  32'(bus.mem_req), 32'd0);
      chk("rstx_busy_off", 32'(bus.busy), 32'd0);
      chk("rstx_no_wr",    32'(bus.rf_we3), 32'd0);
      chk("rstx_no_done",  32'(bus.done), 32'd0);
      @(posedge clk); #1;
    end

    // LDM of R15 alone
    t = '{l:1, p:0, u:1, w:0, rn:4'd0, base:32'h0700, reglist:16'h8000};
    drive_txn(t); bus.start = 1'b1; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0000_8003;
    @(negedge clk);
    @(posedge clk); #1; bus.start = 1'b0;
    @(negedge clk);
`ifdef LDM_STM_PC_LOAD_EN
    chk("pc_req",   32'(bus.mem_req), 32'd1);
    chk("pc_load",  32'(bus.pc_load), 32'd1);
    chk("pc_val",   bus.pc_value, 32'h0000_8000);
    chk("pc_we3",   32'(bus.rf_we3), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pc_done",  32'(bus.done), 32'd1);
`else
    chk("pc_req",   32'(bus.mem_req), 32'd0);
    chk("pc_load",  32'(bus.pc_load), 32'd0);
    chk("pc_done",  32'(bus.done), 32'd1);
`endif
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;

    // Randomized transfers against the reference
    for (int r = 0; r < 40; r++) begin
      t.l = 1'($urandom); t.p = 1'($urandom); t.u = 1'($urandom); t.w = 1'($urandom);
      t.rn = 4'($urandom_range(15));
      t.base = {$urandom_range(32'hFFFF_FFFF) >> 2, 2'b00};
      t.base = {t.base[29:0], 2'b00};
      t.reglist = (r % 3 == 0) ? 16'($urandom & $urandom) : 16'($urandom);
      for (int i = 0; i < 15; i++) regs[i] = $urandom;
      regs[t.rn] = t.base;
      r0 = regs;
      salt = $urandom;
      run_txn(t, 60);
      check_model(t, r0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ldm_stm_seq.md
Name: ldm_stm_seq

Overview:
- Multi-cycle sequencer for ARM block transfers (LDM/STM).
- Sits beside the register file: drives its write port for loads, its second read port for stores, and the base-register writeback.
- Walks a 16-bit register list lowest-index-first, one word per accepted memory handshake.
- Holds the single-cycle datapath stalled via `busy` until the list is exhausted.

Parameters:
- AW, 32, address/data width (fixed at 32 for ARM words; kept as a parameter for bench use only)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse: decoded LDM/STM presented, sampled only in IDLE
- l_bit  input  1  1 = LDM (load), 0 = STM (store)
- p_bit  input  1  1 = pre-index (before), 0 = post-index (after)
- u_bit  input  1  1 = increment, 0 = decrement
- w_bit  input  1  base writeback enable
- rn  input  4  base register index
- base  input  32  base register value (RD1) at start
- reglist  input  16  register list
- rf_rd2  input  32  register file RD2 (store data)
- rf_a2  output  4  register file A2 (store source index)
- rf_a3  output  4  register file A3
- rf_wd3  output  32  register file WD3
- rf_we3  output  1  register file WE3
- mem_req  output  1  memory request valid
- mem_we  output  1  1 = write (STM)
- mem_addr  output  32  word address, bits [1:0] always 0
- mem_wdata  output  32  store data
- mem_ready  input  1  memory accepts/completes the current request this cycle
- mem_rdata  input  32  load data, valid when mem_ready=1
- pc_load  output  1  LDM loaded R15 this cycle
- pc_value  output  32  value for PC when pc_load=1
- busy  output  1  stall to datapath: start | (state != IDLE)
- done  output  1  one-cycle pulse at completion

Behaviour:
- Reset: state=IDLE; mem_req, rf_we3, pc_load, done, busy = 0. All latched registers cleared. Reset mid-transfer abandons remaining words and performs no writeback.
- start ignored unless state=IDLE.
- At start, latch: remaining list, l/p/u/w, rn, base, n = popcount(reglist).
- Start address (all arithmetic mod 2^32):
  - IA (p=0, u=1): base
  - IB (p=1, u=1): base+4
  - DA (p=0, u=0): base-4n+4
  - DB (p=1, u=0): base-4n
- Writeback value: base+4n (u=1) or base-4n (u=0).
- States:
  - IDLE:
    - start with n>0 -> XFER.
    - start with n=0 -> DONE. No memory access, no writeback.
  - XFER:
    - mem_req=1; mem_addr=current address; mem_we=~l; rf_a2=lowest set index.
    - mem_wdata=rf_rd2 (combinational).
    - Address and index stable until the cycle mem_req & mem_ready.
    - In that cycle:
      - LDM with index!=15: rf_we3=1, rf_a3=index, rf_wd3=mem_rdata (same cycle).
      - Clear the index bit; address += 4.
    - Last bit cleared -> WB if w_bit=1 and writeback not suppressed, else DONE.
  - WB: one cycle. rf_we3=1, rf_a3=rn, rf_wd3=writeback value. -> DONE.
  - DONE: done=1 for exactly one cycle. -> IDLE. busy deasserts the following cycle.
- Writeback suppression: LDM with reglist[rn]=1 skips WB; the loaded value wins.
- STM with rn in the list stores the original base (writeback happens after all stores).
- STM of R15 stores whatever the register file returns for index 15 (PC+8).
- rf_we3 is never asserted with rf_a3=15.
- mem_ready while mem_req=0 is ignored.

Optional Feature:
- LDM_STM_PC_LOAD_EN defined:
  - LDM with reglist[15]=1 loads R15 normally.
  - In its handshake cycle: pc_load=1, pc_value={mem_rdata[31:2],2'b00}, rf_we3=0.
- Undefined:
  - Bit 15 is removed from the latched list at start and n excludes it. No memory access for R15.
  - pc_load is tied 0 and pc_value to 0.
  - STM behaviour is unchanged.

Test Plan:
- LDM IA, base=0x1000, reglist=0x000E, mem_ready always 1 -> addresses 0x1000/0x1004/0x1008 on 3 consecutive cycles; R1,R2,R3 written with mem_rdata; done on cycle 4.
- STM DB with writeback, rn=13, base=0x2000, reglist=0x4030 -> stores R4@0x1FF4, R5@0x1FF8, R14@0x1FFC; WB cycle writes R13=0x1FF4.
- LDM IB, reglist=0x0001, mem_ready held low 3 cycles -> mem_addr=base+4 held stable 3 cycles; R0 written only in the ready cycle; busy high throughout.
- LDM with writeback, rn=2, reglist=0x0006 -> R2 receives the loaded word; no WB cycle.
- Empty list: start with reglist=0 -> no mem_req; done one cycle after start; no rf_we3. Second start while busy -> ignored.
- reset asserted mid-transfer (after 1 of 4 words) -> next cycle: mem_req=0, busy=0, no writeback. With LDM_STM_PC_LOAD_EN, reglist=0x8000, mem_rdata=0x00008003 -> pc_load=1, pc_value=0x00008000.
